fifo_rd_ctrl: RTL and testbench

//   Read-side control for the async FIFO, in the rclk domain. Keeps the binary and Gray

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/gray_to_bin.sv | 21 ++
 rtl/fifo_rd_ctrl.sv | 93 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg: pointer widths and Gray/binary helpers shared by both FIFO sides.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_PTR_W      = FIFO_ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2(32) shift steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_bin.sv
// ---------------------------------------------------------------------------
// gray_to_bin: combinational Gray-to-binary converter of parameterised width.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl: async FIFO read-side pointers, RAM read address and empty flag.
// Optional almost-empty flag built only when FIFO_ALMOST_EMPTY_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AE_THRESH  = 1
) (
  input  logic                  rclk,
  input  logic                  rrstn,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic                  r_underflow,
  output logic                  rd_almost_empty
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] rbin_q, rbin_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             rempty_q, rempty_d;
  logic             r_underflow_q, r_underflow_d;
  logic             pop;

  // Empty compares the next Gray pointer against the freshly synchronised
  // write pointer, so a write landing in the same cycle as a pop is never lost.
  always_comb begin
    pop           = rinc && !rempty_q;
    rbin_d        = rbin_q + PTR_W'(pop);
    rptr_d        = PTR_W'(bin2gray(32'(rbin_d)));
    rempty_d      = (rptr_d == rq2_wptr);
    r_underflow_d = rinc && rempty_q;
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      rbin_q        <= '0;
      rptr_q        <= '0;
      rempty_q      <= 1'b1;
      r_underflow_q <= 1'b0;
    end else begin
      rbin_q        <= rbin_d;
      rptr_q        <= rptr_d;
      rempty_q      <= rempty_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  assign raddr       = rbin_q[ADDR_WIDTH-1:0];
  assign rptr        = rptr_q;
  assign rempty      = rempty_q;
  assign r_underflow = r_underflow_q;

`ifdef FIFO_ALMOST_EMPTY_EN
  logic [PTR_W-1:0] wbin_s;
  logic [PTR_W-1:0] fill;
  logic             rd_ae_q;

  gray_to_bin #(
    .WIDTH (PTR_W)
  ) u_gray_to_bin (
    .gray_i (rq2_wptr),
    .bin_o  (wbin_s)
  );

  assign fill = wbin_s - rbin_d;

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      rd_ae_q <= 1'b1;
    end else begin
      rd_ae_q <= (fill <= PTR_W'(AE_THRESH));
    end
  end

  assign rd_almost_empty = rd_ae_q;
`else
  logic ae_thresh_unused;
  assign ae_thresh_unused = (AE_THRESH != 0);
  assign rd_almost_empty  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl: scoreboard bench for the FIFO read-side controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_rd_ctrl;

  logic       rclk  = 1'b0;
  logic       rrstn = 1'b0;
  logic       rinc  = 1'b0;
  logic [3:0] rq2_wptr = 4'd0;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic       r_underflow;
  logic       rd_almost_empty;

  fifo_rd_ctrl #(
    .ADDR_WIDTH (3),
    .AE_THRESH  (1)
  ) dut (
    .rclk            (rclk),
    .rrstn           (rrstn),
    .rinc            (rinc),
    .rq2_wptr        (rq2_wptr),
    .raddr           (raddr),
    .rptr            (rptr),
    .rempty          (rempty),
    .r_underflow     (r_underflow),
    .rd_almost_empty (rd_almost_empty)
  );

  always #5 rclk = ~rclk;

`ifdef FIFO_ALMOST_EMPTY_EN
  localparam bit AE_ON = 1'b1;
`else
  localparam bit AE_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] rptr;
    logic [2:0] raddr;
    logic       empty;
    logic       uf;
    logic       ae;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: binary read count, binary write count, empty flag.
  int   m_rbin  = 0;
  int   m_wcnt  = 0;
  bit   m_empty = 1'b1;

  logic [3:0] gray_lut [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic drive_cycle(input bit inc, input int wc);
    int   nxt;
    bit   pop;
    exp_t e;
    rinc     = inc;
    rq2_wptr = gray_lut[wc & 15];
    pop      = inc && !m_empty;
    nxt      = (m_rbin + int'(pop)) & 15;
    e.rptr   = gray_lut[nxt];
    e.raddr  = 3'(nxt & 7);
    e.empty  = (nxt == (wc & 15));
    e.uf     = inc && m_empty;
    e.ae     = AE_ON ? (((wc - nxt) & 15) <= 1) : 1'b0;
    sbq.push_back(e);
    @(posedge rclk);
    #1;
    m_rbin  = nxt;
    m_wcnt  = wc;
    m_empty = e.empty;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.rptr  = 4'h0;
    e.raddr = 3'd0;
    e.empty = 1'b1;
    e.uf    = 1'b0;
    e.ae    = AE_ON;
    sbq.push_back(e);
    m_rbin  = 0;
    m_wcnt  = 0;
    m_empty = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rrstn = 1'b0; rinc = 1'b0; rq2_wptr = 4'd0;
    #23;
    push_reset_exp();
    e = sbq.pop_front();
    checks++;
    if ({rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
      failures++;
      $display("FAIL reset: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
               rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
    end
    @(negedge rclk); rrstn = 1'b1;
    @(posedge rclk); #1;
  endtask

  task automatic test_empty_latency();
    exp_t e;
    drive_cycle(1'b0, 1);
    drive_cycle(1'b1, 1);
    for (int k = 0; k < 2; k++) begin
      e = sbq.pop_front();
      checks++;
      if (k == 1 && {rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
        failures++;
        $display("FAIL empty_latency_pop: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
                 rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
      end
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1);
      e = sbq.pop_front();
      checks++;
      if ({rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
        failures++;
        $display("FAIL underflow[%0d]: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
                 k, rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    rrstn = 1'b0; rinc = 1'b0; rq2_wptr = 4'd0;
    #2;
    push_reset_exp();
    e = sbq.pop_front();
    checks++;
    if ({rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
      failures++;
      $display("FAIL reset_mid: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
               rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
    end
    @(negedge rclk); rrstn = 1'b1;
    @(posedge rclk); #1;
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [3:0] prev;
    prev = rptr;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, m_wcnt + 1);
      void'(sbq.pop_front());
      drive_cycle(1'b1, m_wcnt);
      e = sbq.pop_front();
      checks++;
      if ({rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
        failures++;
        $display("FAIL wrap[%0d]: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
                 i, rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
      end
      checks++;
      if ($countones(rptr ^ prev) != 1) begin
        failures++;
        $display("FAIL wrap_onebit[%0d]: got rptr=%h after %h, exp exactly one bit change", i, rptr, prev);
      end
      prev = rptr;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int   base;
    base = m_wcnt;
    drive_cycle(1'b0, base + 2);
    drive_cycle(1'b1, base + 2);
    drive_cycle(1'b1, base + 3);
    drive_cycle(1'b1, base + 3);
    for (int k = 0; k < 4; k++) begin
      e = sbq.pop_front();
      if (k >= 2) begin
        checks++;
        if (e.rptr !== (k == 2 ? 4'h3 : 4'h2) || e.empty !== (k == 3)) begin
          failures++;
          $display("FAIL simultaneous_model[%0d]: got rptr=%h rempty=%b from scoreboard", k, e.rptr, e.empty);
        end
      end
    end
    checks++;
    if ({rptr, raddr, rempty, r_underflow} !== {4'h2, 3'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL simultaneous_drain: got rptr=%h raddr=%0d rempty=%b uf=%b, exp rptr=2 raddr=3 rempty=1 uf=0",
               rptr, raddr, rempty, r_underflow);
    end
  endtask

  task automatic test_simultaneous_edge();
    exp_t e;
    int   base;
    base = m_wcnt;
    drive_cycle(1'b0, base + 2);
    void'(sbq.pop_front());
    drive_cycle(1'b1, base + 2);
    void'(sbq.pop_front());
    drive_cycle(1'b1, base + 3);
    e = sbq.pop_front();
    checks++;
    if ({rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
      failures++;
      $display("FAIL simultaneous: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
               rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
    end
    drive_cycle(1'b1, m_wcnt);
    e = sbq.pop_front();
    checks++;
    if ({rptr, rempty} !== {e.rptr, e.empty}) begin
      failures++;
      $display("FAIL simultaneous_empty: got rptr=%h rempty=%b, exp rptr=%h rempty=%b", rptr, rempty, e.rptr, e.empty);
    end
  endtask

  task automatic test_almost_empty();
    exp_t e;
    int   base;
    base = m_wcnt;
    drive_cycle(1'b0, base + 3);
    drive_cycle(1'b1, base + 3);
    drive_cycle(1'b1, base + 3);
    drive_cycle(1'b1, base + 3);
    for (int k = 0; k < 4; k++) begin
      e = sbq.pop_front();
      checks++;
      if (k == 3 && {rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
        failures++;
        $display("FAIL almost_empty_final: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
                 rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
      end
    end
  endtask

  task automatic test_almost_empty_steps();
    exp_t e;
    int   base;
    base = m_wcnt;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(k != 0, base + 3);
      e = sbq.pop_front();
      checks++;
      if ({rempty, rd_almost_empty} !== {e.empty, e.ae}) begin
        failures++;
        $display("FAIL almost_empty[%0d]: got rempty=%b ae=%b, exp rempty=%b ae=%b", k, rempty, rd_almost_empty, e.empty, e.ae);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b1, m_wcnt + 1);
      e = sbq.pop_front();
      checks++;
      if ({rptr, raddr, rempty, r_underflow, rd_almost_empty} !== {e.rptr, e.raddr, e.empty, e.uf, e.ae}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got rptr=%h raddr=%0d rempty=%b uf=%b ae=%b, exp rptr=%h raddr=%0d rempty=%b uf=%b ae=%b",
                 k, rptr, raddr, rempty, r_underflow, rd_almost_empty, e.rptr, e.raddr, e.empty, e.uf, e.ae);
      end
    end
    drive_cycle(1'b1, m_wcnt);
    e = sbq.pop_front();
    checks++;
    if ({rptr, rempty, r_underflow} !== {e.rptr, e.empty, e.uf}) begin
      failures++;
      $display("FAIL back_to_back_drain: got rptr=%h rempty=%b uf=%b, exp rptr=%h rempty=%b uf=%b",
               rptr, rempty, r_underflow, e.rptr, e.empty, e.uf);
    end
  endtask

  initial begin
    test_reset();
    test_empty_latency();
    test_underflow();
    test_reset_mid();
    test_wrap();
    test_simultaneous();
    test_simultaneous_edge();
    test_almost_empty();
    test_almost_empty_steps();
    test_back_to_back();
    rinc = 1'b0;
    repeat (2) @(posedge rclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
